branch_cmp_pred: RTL and testbench

BRANCH_CMP_PRED -- requirements
Module: branch_cmp_pred

---
 rtl/branch_pkg.sv | 33 +++
 rtl/branch_pht.sv | 45 ++++
 rtl/branch_cmp_pred.sv | 122 ++++++++++++
 tb/tb_branch_cmp_pred.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch compare/predict block:
// condition-code encodings and 2-bit predictor counter states.
package branch_pkg;

    typedef enum logic [2:0] {
        CMP_EQ     = 3'd0,
        CMP_NE     = 3'd1,
        CMP_LEZ    = 3'd2,
        CMP_GTZ    = 3'd3,
        CMP_LTZ    = 3'd4,
        CMP_GEZ    = 3'd5,
        CMP_ALWAYS = 3'd6,
        CMP_NEVER  = 3'd7
    } cmp_e;

    localparam logic [1:0] SNT = 2'd0;  // strongly not-taken
    localparam logic [1:0] WNT = 2'd1;  // weakly not-taken
    localparam logic [1:0] WT  = 2'd2;  // weakly taken
    localparam logic [1:0] ST  = 2'd3;  // strongly taken

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != ST) res = cnt + 2'd1;
        end else begin
            if (cnt != SNT) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: PHT_DEPTH 2-bit counters, asynchronous read,
// synchronous write. Every entry resets to weakly not-taken, so the
// table is built from flops rather than block RAM.
module branch_pht
    import branch_pkg::*;
#(
    parameter int PHT_DEPTH = 16,
    localparam int IDX_W    = $clog2(PHT_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_data
);

    logic [1:0] entry_reg  [PHT_DEPTH];
    logic [1:0] entry_next [PHT_DEPTH];

    // Per-entry write decode: only the addressed entry takes the new value.
    generate
        for (genvar gi = 0; gi < PHT_DEPTH; gi++) begin : g_entry
            assign entry_next[gi] = (wr_en && (wr_idx == IDX_W'(gi))) ? wr_data : entry_reg[gi];
        end
    endgenerate

    // Table state: reset all entries to WNT, otherwise apply the decoded write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                entry_reg[i] <= WNT;
            end
        end else begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    // Read returns the pre-write value when read and write collide.
    assign rd_data = entry_reg[rd_idx];

endmodule

// File: rtl/branch_cmp_pred.sv
// Branch resolution stage: evaluates the branch condition on forwarded
// operands, predicts with a 2-bit bimodal table, registers the outcome
// and mispredict flag one cycle later, and keeps branch/miss statistics.
module branch_cmp_pred
    import branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PHT_DEPTH = 16,
    parameter int IDX_LSB   = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [31:0]      pc,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             pred_taken,
    output logic             valid_out,
    output logic             taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic [IDX_W-1:0] idx;
    logic [1:0]       pht_rd;
    logic [1:0]       pht_wr;
    logic             accepted;
    logic             outcome;
    logic             miss;
    logic             rd1_neg;
    logic             rd1_zero;
    logic             unused_pc_bits;

    logic             valid_out_reg;
    logic             taken_reg;
    logic             mispredict_reg;
    logic [CNT_W-1:0] br_cnt_reg;
    logic [CNT_W-1:0] miss_cnt_reg;

    assign idx            = pc[IDX_LSB +: IDX_W];
    assign unused_pc_bits = ^pc;

    branch_pht #(
        .PHT_DEPTH (PHT_DEPTH)
    ) u_pht (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_idx  (idx),
        .rd_data (pht_rd),
        .wr_en   (accepted),
        .wr_idx  (idx),
        .wr_data (pht_wr)
    );

    assign pred_taken = pht_rd[1];
    assign accepted   = valid_in && en && !flush;
    assign pht_wr     = sat_update(pht_rd, outcome);
    assign miss       = (outcome != pred_taken);

    assign rd1_neg  = rd1[WIDTH-1];
    assign rd1_zero = (rd1 == '0);

    // Condition evaluation; sign tests treat rd1 as two's complement.
    always_comb begin
        outcome = 1'b0;
        case (cond)
            CMP_EQ:     outcome = (rd1 == rd2);
            CMP_NE:     outcome = (rd1 != rd2);
            CMP_LEZ:    outcome = rd1_neg || rd1_zero;
            CMP_GTZ:    outcome = !rd1_neg && !rd1_zero;
            CMP_LTZ:    outcome = rd1_neg;
            CMP_GEZ:    outcome = !rd1_neg;
            CMP_ALWAYS: outcome = 1'b1;
            CMP_NEVER:  outcome = 1'b0;
            default:    outcome = 1'b0;
        endcase
    end

    // Result register: reset > flush > stall; idle slots read as all-zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_out_reg  <= 1'b0;
            taken_reg      <= 1'b0;
            mispredict_reg <= 1'b0;
        end else if (flush) begin
            valid_out_reg  <= 1'b0;
            taken_reg      <= 1'b0;
            mispredict_reg <= 1'b0;
        end else if (en) begin
            valid_out_reg  <= valid_in;
            taken_reg      <= valid_in && outcome;
            mispredict_reg <= valid_in && miss;
        end
    end

    // Statistics counters advance only on accepted branches and wrap freely.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            br_cnt_reg   <= '0;
            miss_cnt_reg <= '0;
        end else if (accepted) begin
            br_cnt_reg <= br_cnt_reg + CNT_W'(1);
            if (miss) begin
                miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign valid_out  = valid_out_reg;
    assign taken      = taken_reg;
    assign mispredict = mispredict_reg;
    assign br_cnt     = br_cnt_reg;
    assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_branch_cmp_pred.sv
// Self-checking bench for branch_cmp_pred: directed scenarios followed by
// random traffic, compared against a behavioural predictor/statistics model.
// A second instance with CNT_W=4 shares the stimulus to exercise counter wrap.
module tb_branch_cmp_pred;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        flush;
    logic        valid_in;
    logic [31:0] pc;
    logic [2:0]  cond;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic        pred_taken, valid_out, taken, mispredict;
    logic [31:0] br_cnt, miss_cnt;
    logic        pred_taken4, valid_out4, taken4, mispredict4;
    logic [3:0]  br_cnt4, miss_cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          pht_m [16];
    int unsigned br_m;
    int unsigned miss_m;
    bit          ev, et, em;
    bit          inited = 0;

    always #5 clk = ~clk;

    branch_cmp_pred dut (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .valid_in(valid_in),
        .pc(pc), .cond(cond), .rd1(rd1), .rd2(rd2),
        .pred_taken(pred_taken), .valid_out(valid_out), .taken(taken),
        .mispredict(mispredict), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    branch_cmp_pred #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .valid_in(valid_in),
        .pc(pc), .cond(cond), .rd1(rd1), .rd2(rd2),
        .pred_taken(pred_taken4), .valid_out(valid_out4), .taken(taken4),
        .mispredict(mispredict4), .br_cnt(br_cnt4), .miss_cnt(miss_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_outcome(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) <= 0;
            3'd3:    return $signed(a) > 0;
            3'd4:    return $signed(a) < 0;
            3'd5:    return $signed(a) >= 0;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive inputs, check prediction, predict next state, check outputs.
    task automatic cycle(input bit rn, input bit v, input bit f, input bit e,
                         input logic [2:0] c, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        int idx;
        bit exp_pred;
        bit o;
        reset_n = rn; valid_in = v; flush = f; en = e;
        cond = c; pc = p; rd1 = a; rd2 = b;
        #1;
        idx      = int'((p >> 2) & 32'hF);
        exp_pred = (pht_m[idx] >= 2);
        o        = ref_outcome(c, a, b);
        if (inited) chk("pred_taken", 32'(pred_taken), 32'(exp_pred));

        if (!rn) begin
            for (int i = 0; i < 16; i++) pht_m[i] = 1;
            ev = 0; et = 0; em = 0; br_m = 0; miss_m = 0;
            inited = 1;
        end else if (f) begin
            ev = 0; et = 0; em = 0;
        end else if (e) begin
            if (v) begin
                ev = 1; et = o; em = (o != exp_pred);
                br_m++;
                if (em) miss_m++;
                if (o) pht_m[idx] = (pht_m[idx] == 3) ? 3 : pht_m[idx] + 1;
                else   pht_m[idx] = (pht_m[idx] == 0) ? 0 : pht_m[idx] - 1;
            end else begin
                ev = 0; et = 0; em = 0;
            end
        end

        @(posedge clk);
        #1;
        $display("cyc rn=%0d v=%0d f=%0d en=%0d cond=%0d pc=%h rd1=%h rd2=%h | vo=%0d t=%0d m=%0d br=%0d miss=%0d br4=%0d",
                 rn, v, f, e, c, p, a, b, valid_out, taken, mispredict, br_cnt, miss_cnt, br_cnt4);
        chk("valid_out",  32'(valid_out),  32'(ev));
        chk("taken",      32'(taken),      32'(et));
        chk("mispredict", 32'(mispredict), 32'(em));
        chk("br_cnt",     br_cnt,          br_m);
        chk("miss_cnt",   miss_cnt,        miss_m);
        chk("valid_out4", 32'(valid_out4), 32'(ev));
        chk("br_cnt4",    32'(br_cnt4),    br_m & 32'hF);
        chk("miss_cnt4",  32'(miss_cnt4),  miss_m & 32'hF);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset_n = 0; en = 0; flush = 0; valid_in = 0;
        pc = 0; cond = 0; rd1 = 0; rd2 = 0;

        // Reset state
        cycle(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 0, 1, 3'd0, 32'h0, 32'h0, 32'h0);
        chk("rst_br_cnt", br_cnt, 32'd0);

        // First taken EQ branch at 0x3000 mispredicts
        cycle(1, 1, 0, 1, 3'd0, 32'h3000, 32'd5, 32'd5);
        chk("first_taken", 32'(taken), 32'd1);
        chk("first_miss", miss_cnt, 32'd1);

        // Same branch twice more: counter saturates, prediction turns taken
        cycle(1, 1, 0, 1, 3'd0, 32'h3000, 32'd5, 32'd5);
        chk("second_nomiss", 32'(mispredict), 32'd0);
        cycle(1, 1, 0, 1, 3'd0, 32'h3000, 32'd5, 32'd5);
        chk("third_pred", 32'(pred_taken), 32'd1);

        // Sign-test boundaries
        cycle(1, 1, 0, 1, 3'd4, 32'h3004, 32'h8000_0000, 32'h0);
        chk("ltz_min", 32'(taken), 32'd1);
        cycle(1, 1, 0, 1, 3'd5, 32'h3008, 32'h0, 32'h0);
        chk("gez_zero", 32'(taken), 32'd1);
        cycle(1, 1, 0, 1, 3'd3, 32'h300C, 32'h0, 32'h0);
        chk("gtz_zero", 32'(taken), 32'd0);
        cycle(1, 1, 0, 1, 3'd2, 32'h3010, 32'h0, 32'h0);
        cycle(1, 1, 0, 1, 3'd1, 32'h3014, 32'd7, 32'd7);

        // Accepted branch, three stall cycles, then flush during stall
        cycle(1, 1, 0, 1, 3'd6, 32'h3020, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 3'd6, 32'h3020, 32'h0, 32'h0);
        chk("stall_hold_vo", 32'(valid_out), 32'd1);
        cycle(1, 1, 1, 0, 3'd6, 32'h3020, 32'h0, 32'h0);
        chk("flush_vo", 32'(valid_out), 32'd0);
        cycle(1, 1, 1, 1, 3'd6, 32'h3020, 32'h0, 32'h0);
        cycle(1, 0, 0, 1, 3'd6, 32'h3020, 32'h0, 32'h0);

        // Branch presented during reset is discarded; entry stays weakly not-taken
        cycle(0, 1, 0, 1, 3'd6, 32'h3000, 32'h0, 32'h0);
        chk("rst_branch_vo", 32'(valid_out), 32'd0);
        cycle(1, 1, 0, 1, 3'd6, 32'h3000, 32'h0, 32'h0);
        chk("rst_branch_miss", 32'(mispredict), 32'd1);

        // 17 accepted branches wrap the 4-bit counter to 1
        cycle(0, 0, 0, 1, 3'd0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 17; i++) cycle(1, 1, 0, 1, 3'(i % 8), 32'(i * 4), 32'(i), 32'd3);
        chk("wrap_br_cnt4", 32'(br_cnt4), 32'd1);
        chk("wrap_br_cnt", br_cnt, 32'd17);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 5) != 0),
                  3'($urandom_range(0, 7)),
                  {$urandom_range(0, 255), 2'($urandom_range(0, 3))} & 32'h3FF,
                  rand_opnd(), rand_opnd());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
